// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : shift_arbiter
//  Purpose  : Sequencing controller and two-requester round-robin arbiter for
//             a shared 32-bit combinational left barrel shifter. Logical right,
//             arithmetic right and rotate-left operations are built from the
//             left-only shifter using bit reversal, inversion and a second
//             pass. Results come back tagged with the owning requester over a
//             valid/ready response channel.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FIRST_GRANT   requester that wins the first simultaneous contention
//                  after reset (0 or 1)
//  Ports
//    clock, reset_n             system clock (rising edge), async active-low reset
//    req{0,1}_valid / _ready    request handshake per requester
//    req{0,1}_data/_shamt/_op   operand, shift amount, op (0 SLL,1 SRL,2 SRA,3 ROL)
//    sh_data, sh_shamt          drive to the shared shifter inputs
//    sh_result                  shared shifter combinational output
//    resp_valid / resp_ready    response handshake
//    resp_id, resp_result       owning requester and shift result
//    busy                       high whenever the controller is not idle
// ============================================================================
module shift_arbiter #(
    parameter int FIRST_GRANT = 0
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_shamt,
    input  logic [1:0]  req0_op,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_shamt,
    input  logic [1:0]  req1_op,

    output logic [31:0] sh_data,
    output logic [4:0]  sh_shamt,
    input  logic [31:0] sh_result,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_result,
    output logic        busy
);

    // ------------------------------------------------------------------------
    // Constants and state encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_op_sll = 2'd0;
    localparam logic [1:0] c_op_srl = 2'd1;
    localparam logic [1:0] c_op_sra = 2'd2;
    localparam logic [1:0] c_op_rol = 2'd3;

    localparam logic c_first_grant = (FIRST_GRANT != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Bit reversal: x[i] -> x[31-i]. Turns a left shift into a right shift.
    function automatic logic [31:0] f_rev(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) begin
            y[i] = x[31-i];
        end
        return y;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_data;
    logic [4:0]  r_shamt;
    logic [1:0]  r_op;
    logic        r_id;
    logic        r_last_grant;
    logic [31:0] r_partial;
    logic [31:0] r_result;
    logic [31:0] r_sh_data_hold;
    logic [4:0]  r_sh_shamt_hold;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic        w_grant;
    logic        w_accept;
    logic        w_sra_neg;
    logic [31:0] w_pass1_result;

    // ------------------------------------------------------------------------
    // Round-robin grant. On contention the requester that was not served
    // last wins; a lone requester always wins.
    // ------------------------------------------------------------------------
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_accept   = (r_state == ST_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = (r_state == ST_IDLE) && req0_valid && !w_grant;
    assign req1_ready = (r_state == ST_IDLE) && req1_valid &&  w_grant;

    // Arithmetic right shift of a negative operand: shift the complement in
    // with zeros, then complement the result so the vacated bits become ones.
    assign w_sra_neg = (r_op == c_op_sra) && r_data[31];

    // ------------------------------------------------------------------------
    // Shared shifter drive. Outside the two pass states the last driven
    // values are held so the shifter inputs do not toggle needlessly.
    // ------------------------------------------------------------------------
    always_comb begin
        sh_data  = r_sh_data_hold;
        sh_shamt = r_sh_shamt_hold;
        case (r_state)
            ST_PASS1: begin
                sh_shamt = r_shamt;
                case (r_op)
                    c_op_srl: sh_data = f_rev(r_data);
                    c_op_sra: sh_data = w_sra_neg ? f_rev(~r_data) : f_rev(r_data);
                    default:  sh_data = r_data;            // SLL and ROL
                endcase
            end
            ST_PASS2: begin
                // Second rotate pass recovers the bits shifted out on the left:
                // rev(rev(d) << (32-s)) == d >> (32-s). 32-s fits in 5 bits
                // because this pass only runs for s in 1..31.
                sh_data  = f_rev(r_data);
                sh_shamt = 5'd0 - r_shamt;
            end
            default: begin
            end
        endcase
    end

    // First-pass result mapping back out of the left-shift domain.
    always_comb begin
        w_pass1_result = sh_result;
        case (r_op)
            c_op_srl: w_pass1_result = f_rev(sh_result);
            c_op_sra: w_pass1_result = w_sra_neg ? ~f_rev(sh_result) : f_rev(sh_result);
            default:  w_pass1_result = sh_result;          // SLL and ROL
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_PASS1;
                end
            end
            ST_PASS1: begin
                // A rotate by zero is complete after the first pass.
                if ((r_op == c_op_rol) && (r_shamt != 5'd0)) begin
                    w_next_state = ST_PASS2;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            ST_PASS2: begin
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data          <= '0;
            r_shamt         <= '0;
            r_op            <= '0;
            r_id            <= 1'b0;
            r_last_grant    <= ~c_first_grant;
            r_partial       <= '0;
            r_result        <= '0;
            r_sh_data_hold  <= '0;
            r_sh_shamt_hold <= '0;
        end else begin
            if (w_accept) begin
                r_data       <= w_grant ? req1_data  : req0_data;
                r_shamt      <= w_grant ? req1_shamt : req0_shamt;
                r_op         <= w_grant ? req1_op    : req0_op;
                r_id         <= w_grant;
                r_last_grant <= w_grant;
            end

            if ((r_state == ST_PASS1) || (r_state == ST_PASS2)) begin
                r_sh_data_hold  <= sh_data;
                r_sh_shamt_hold <= sh_shamt;
            end

            if (r_state == ST_PASS1) begin
                // For a rotate the first pass is the left-shifted half; it
                // also serves as the final result when the amount is zero.
                r_partial <= sh_result;
                r_result  <= w_pass1_result;
            end

            if (r_state == ST_PASS2) begin
                r_result <= r_partial | f_rev(sh_result);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign resp_valid  = (r_state == ST_RESP);
    assign resp_id     = r_id;
    assign resp_result = r_result;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_arbiter
//  Purpose  : Self-checking bench for shift_arbiter. Models the shared left
//             barrel shifter and compares every response against a plain
//             arithmetic reference of SLL/SRL/SRA/ROL.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;

    logic        clock;
    logic        reset_n;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_data;
    logic [4:0]  req0_shamt;
    logic [1:0]  req0_op;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_data;
    logic [4:0]  req1_shamt;
    logic [1:0]  req1_op;
    logic [31:0] sh_data;
    logic [4:0]  sh_shamt;
    logic [31:0] sh_result;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_result;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    shift_arbiter #(.FIRST_GRANT(0)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_data   (req0_data),
        .req0_shamt  (req0_shamt),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_data   (req1_data),
        .req1_shamt  (req1_shamt),
        .req1_op     (req1_op),
        .sh_data     (sh_data),
        .sh_shamt    (sh_shamt),
        .sh_result   (sh_result),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .busy        (busy)
    );

    // Shared combinational left shifter.
    assign sh_result = sh_data << sh_shamt;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Reference: operations computed directly from their arithmetic meaning.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                              input logic [1:0] op);
        logic [63:0] w;
        case (op)
            2'd0:    return d << s;
            2'd1:    return d >> s;
            2'd2:    return $unsigned($signed(d) >>> s);
            default: begin
                w = {d, d} << s;
                return w[63:32];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] s, input logic [1:0] op);
        return (op == 2'd3 && s != 5'd0) ? 3 : 2;
    endfunction

    task automatic apply_reset();
        reset_n    = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Drives one transaction on a port with resp_ready high and reports what
    // came back; callers do the comparisons.
    task automatic do_op(input bit port, input logic [31:0] d, input logic [4:0] s,
                         input logic [1:0] op, output logic [31:0] res, output logic id,
                         output int lat, output bit ok);
        int c0;
        bit got;
        ok = 1'b0; res = '0; id = 1'b0; lat = -1; c0 = 0; got = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        if (port == 1'b0) begin
            req0_valid = 1'b1; req0_data = d; req0_shamt = s; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_data = d; req1_shamt = s; req1_op = op;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if ((port == 1'b0 && req0_ready) || (port == 1'b1 && req1_ready)) begin
                got = 1'b1;
                c0  = cyc;
            end else begin
                @(negedge clock);
            end
        end
        @(posedge clock);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (got) begin
            for (int i = 0; i < 10 && !ok; i++) begin
                @(negedge clock);
                if (resp_valid) begin
                    lat = cyc - c0;
                    res = resp_result;
                    id  = resp_id;
                    ok  = 1'b1;
                end
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        req0_data = '0; req0_shamt = '0; req0_op = '0;
        req1_data = '0; req1_shamt = '0; req1_op = '0;
        repeat (3) @(negedge clock);
        checks++;
        if (resp_valid !== 1'b0 || resp_id !== 1'b0 || resp_result !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b id=%b result=%h busy=%b, expected 0 0 00000000 0",
                     resp_valid, resp_id, resp_result, busy);
        end
        checks++;
        if (sh_data !== 32'h0 || sh_shamt !== 5'h0) begin
            errors++;
            $display("FAIL reset_shifter: got sh_data=%h sh_shamt=%h, expected 0 0", sh_data, sh_shamt);
        end
        reset_n = 1'b1;
        @(negedge clock);
        req1_valid = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_lone_grant: got ready0=%b ready1=%b, expected 0 1", req0_ready, req1_ready);
        end
        req1_valid = 1'b0;
        #1;
        apply_reset();
    endtask

    // Directed cases from a table, including the shift-by-0 and by-31 edges.
    task automatic test_directed();
        logic [31:0] d_t [9] = '{32'h00000001, 32'h00000001, 32'h80000000, 32'h80000000,
                                 32'h7FFFFFFF, 32'h80000001, 32'h80000001, 32'h12345678, 32'hFFFFFFFF};
        logic [4:0]  s_t [9] = '{5'd0, 5'd31, 5'd4, 5'd4, 5'd31, 5'd1, 5'd0, 5'd16, 5'd31};
        logic [1:0]  o_t [9] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2};
        bit          p_t [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] e_t [9] = '{32'h00000001, 32'h80000000, 32'h08000000, 32'hF8000000,
                                 32'h00000000, 32'h00000003, 32'h80000001, 32'h56781234, 32'hFFFFFFFF};
        int          l_t [9] = '{2, 2, 2, 2, 2, 3, 2, 3, 2};
        logic [31:0] res;
        logic        id;
        int          lat;
        bit          ok;
        for (int i = 0; i < 9; i++) begin
            do_op(p_t[i], d_t[i], s_t[i], o_t[i], res, id, lat, ok);
            checks++;
            if (!ok || res !== e_t[i] || id !== p_t[i] || lat != l_t[i]) begin
                errors++;
                $display("FAIL directed_%0d: got ok=%b result=%h id=%b latency=%0d, expected result=%h id=%b latency=%0d",
                         i, ok, res, id, lat, e_t[i], p_t[i], l_t[i]);
            end
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] exp_res [$];
        bit          exp_id  [$];
        bit          order   [$];
        int          nresp;
        bit          r0, r1, both_seen;
        apply_reset();
        nresp = 0; both_seen = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        req0_data = $urandom; req0_shamt = 5'($urandom); req0_op = 2'($urandom);
        req1_data = $urandom; req1_shamt = 5'($urandom); req1_op = 2'($urandom);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int c = 0; c < 60 && nresp < 4; c++) begin
            if (c != 0) @(negedge clock);
            #1;
            r0 = req0_ready; r1 = req1_ready;
            if (r0 && r1) both_seen = 1'b1;
            if (resp_valid && exp_res.size() > 0) begin
                checks++;
                if (resp_id !== exp_id[0] || resp_result !== exp_res[0]) begin
                    errors++;
                    $display("FAIL arb_response_%0d: got id=%b result=%h, expected id=%b result=%h",
                             nresp, resp_id, resp_result, exp_id[0], exp_res[0]);
                end
                void'(exp_res.pop_front());
                void'(exp_id.pop_front());
                nresp++;
            end
            if (r0) begin
                order.push_back(1'b0); exp_id.push_back(1'b0);
                exp_res.push_back(ref_shift(req0_data, req0_shamt, req0_op));
            end else if (r1) begin
                order.push_back(1'b1); exp_id.push_back(1'b1);
                exp_res.push_back(ref_shift(req1_data, req1_shamt, req1_op));
            end
            @(posedge clock);
            #1;
            if (r0) begin
                req0_data = $urandom; req0_shamt = 5'($urandom); req0_op = 2'($urandom);
            end
            if (r1) begin
                req1_data = $urandom; req1_shamt = 5'($urandom); req1_op = 2'($urandom);
            end
            if (order.size() >= 4) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (both_seen) begin
            errors++;
            $display("FAIL arb_exclusive_ready: got both readies high, expected at most one");
        end
        checks++;
        if (nresp != 4 || order.size() != 4) begin
            errors++;
            $display("FAIL arb_count: got %0d accepts %0d responses, expected 4 4", order.size(), nresp);
        end else begin
            checks++;
            if (order[0] !== 1'b0 || order[1] !== 1'b1 || order[2] !== 1'b0 || order[3] !== 1'b1) begin
                errors++;
                $display("FAIL arb_order: got %b%b%b%b, expected 0101", order[0], order[1], order[2], order[3]);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        logic [31:0] d, v_res, e_res;
        logic        v_id;
        bit          got, seen, stable;
        d = $urandom;
        e_res = ref_shift(d, 5'd7, 2'd3);
        got = 1'b0; seen = 1'b0; stable = 1'b1; v_res = '0; v_id = 1'b0;
        @(negedge clock);
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_data = d; req0_shamt = 5'd7; req0_op = 2'd3;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (req0_ready) got = 1'b1;
            else @(negedge clock);
        end
        @(posedge clock);
        #1;
        req0_valid = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            if (resp_valid) begin
                seen = 1'b1; v_res = resp_result; v_id = resp_id;
            end
        end
        checks++;
        if (!seen || v_res !== e_res || v_id !== 1'b0) begin
            errors++;
            $display("FAIL bp_result: got seen=%b result=%h id=%b, expected 1 %h 0", seen, v_res, v_id, e_res);
        end
        req1_valid = 1'b1; req1_data = $urandom; req1_shamt = '0; req1_op = '0;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clock);
            #1;
            if (resp_valid !== 1'b1 || resp_id !== v_id || resp_result !== v_res || busy !== 1'b1
                || req0_ready !== 1'b0 || req1_ready !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL bp_hold: got valid=%b id=%b result=%h busy=%b rdy=%b%b, expected 1 %b %h 1 00",
                     resp_valid, resp_id, resp_result, busy, req0_ready, req1_ready, v_id, v_res);
        end
        @(negedge clock);
        resp_ready = 1'b1;
        req1_valid = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got valid=%b busy=%b, expected 0 0", resp_valid, busy);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_midop();
        logic [31:0] res;
        logic        id;
        int          lat;
        bit          ok, got, leaked;
        got = 1'b0; leaked = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        req0_valid = 1'b1; req0_data = $urandom; req0_shamt = 5'd9; req0_op = 2'd3;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (req0_ready) got = 1'b1;
            else @(negedge clock);
        end
        @(posedge clock);          // into PASS1
        #1;
        req0_valid = 1'b0;
        @(posedge clock);          // into PASS2
        #2;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midop_busy_before: got busy=%b, expected 1", busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || sh_data !== 32'h0 || sh_shamt !== 5'h0) begin
            errors++;
            $display("FAIL midop_async_reset: got valid=%b busy=%b sh_data=%h sh_shamt=%h, expected 0 0 0 0",
                     resp_valid, busy, sh_data, sh_shamt);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (resp_valid !== 1'b0 || busy !== 1'b0) leaked = 1'b1;
        end
        checks++;
        if (leaked) begin
            errors++;
            $display("FAIL midop_no_response: got a response or busy after reset, expected none");
        end
        do_op(1'b0, 32'h0000F00D, 5'd8, 2'd0, res, id, lat, ok);
        checks++;
        if (!ok || res !== 32'h00F00D00 || id !== 1'b0 || lat != 2) begin
            errors++;
            $display("FAIL midop_fresh_sll: got ok=%b result=%h id=%b latency=%0d, expected 1 00f00d00 0 2",
                     ok, res, id, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, res, e;
        logic [4:0]  s;
        logic [1:0]  op;
        bit          port, ok;
        logic        id;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            d    = $urandom;
            s    = 5'($urandom_range(0, 31));
            op   = 2'($urandom_range(0, 3));
            port = 1'($urandom_range(0, 1));
            if (i % 8 == 0) s = 5'd0;
            e = ref_shift(d, s, op);
            do_op(port, d, s, op, res, id, lat, ok);
            checks++;
            if (!ok || res !== e || id !== port || lat != ref_latency(s, op)) begin
                errors++;
                $display("FAIL random_%0d op=%0d d=%h s=%0d: got ok=%b result=%h id=%b latency=%0d, expected %h %b %0d",
                         i, op, d, s, ok, res, id, lat, e, port, ref_latency(s, op));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_arbitration();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
